// File: rtl/rtc_set_sequencer.sv
// Host-side sequencer that turns one set-time or clear request into the rtc_clock
// command sequence, with an optional idle gap between consecutive commands.
module rtc_set_sequencer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_clear_i,
  input  logic [4:0] req_hours_i,
  input  logic [5:0] req_minutes_i,
  input  logic [5:0] req_seconds_i,
  input  logic [9:0] req_ms_i,
  output logic       cmd_valid_o,
  output logic [2:0] cmd_type_o,
  output logic [9:0] cmd_data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [3:0] {
    IDLE, CMD_RST, CMD_H, CMD_M, CMD_S, CMD_MS, GAP, DONE, ERR
  } state_t;

  state_t     state, state_nxt, ret_q, ret_nxt, follow;
  logic [4:0] hours_q;
  logic [5:0] minutes_q, seconds_q;
  logic [9:0] ms_q;
  logic [3:0] gap_cnt, gap_cnt_nxt;
  logic       accept, fields_bad, is_cmd;
  logic [4:0] hours_src;

  logic       cmd_valid_nxt, busy_nxt, done_nxt, err_nxt;
  logic [2:0] cmd_type_nxt;
  logic [9:0] cmd_data_nxt;

  assign req_ready_o = (state == IDLE) && !srst_i;
  assign accept      = req_valid_i && req_ready_o;
  assign fields_bad  = (req_hours_i > 5'd23) || (req_minutes_i > 6'd59) ||
                       (req_seconds_i > 6'd59) || (req_ms_i > 10'd999);

  // Every command state hands over to its successor, optionally through GAP.
  always_comb begin
    state_nxt   = state;
    ret_nxt     = ret_q;
    gap_cnt_nxt = gap_cnt;
    follow      = IDLE;
    is_cmd      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_clear_i)     state_nxt = CMD_RST;
          else if (fields_bad) state_nxt = ERR;
          else                 state_nxt = CMD_H;
        end
      end
      CMD_RST: begin follow = DONE;   is_cmd = 1'b1; end
      CMD_H:   begin follow = CMD_M;  is_cmd = 1'b1; end
      CMD_M:   begin follow = CMD_S;  is_cmd = 1'b1; end
      CMD_S:   begin follow = CMD_MS; is_cmd = 1'b1; end
      CMD_MS:  begin follow = DONE;   is_cmd = 1'b1; end
      GAP: begin
        if (gap_cnt == 4'd0) state_nxt = ret_q;
        else                 gap_cnt_nxt = gap_cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (is_cmd) begin
      if (GAP_CYCLES > 0) begin
        state_nxt   = GAP;
        ret_nxt     = follow;
        gap_cnt_nxt = 4'(GAP_CYCLES - 1);
      end else begin
        state_nxt = follow;
      end
    end
  end

  // Outputs are registered, so decode them from the state being entered. The
  // hours field is still on the request bus on the accept edge.
  assign hours_src = (state == IDLE) ? req_hours_i : hours_q;

  always_comb begin
    cmd_valid_nxt = 1'b0;
    cmd_type_nxt  = 3'd0;
    cmd_data_nxt  = 10'd0;
    busy_nxt      = (state_nxt != IDLE);
    done_nxt      = (state_nxt == DONE);
    err_nxt       = (state_nxt == ERR);
    case (state_nxt)
      CMD_RST: cmd_valid_nxt = 1'b1;
      CMD_H: begin
        cmd_valid_nxt = 1'b1;
        cmd_type_nxt  = 3'd1;
        cmd_data_nxt  = {5'd0, hours_src};
      end
      CMD_M: begin
        cmd_valid_nxt = 1'b1;
        cmd_type_nxt  = 3'd2;
        cmd_data_nxt  = {4'd0, minutes_q};
      end
      CMD_S: begin
        cmd_valid_nxt = 1'b1;
        cmd_type_nxt  = 3'd3;
        cmd_data_nxt  = {4'd0, seconds_q};
      end
      CMD_MS: begin
        cmd_valid_nxt = 1'b1;
        cmd_type_nxt  = 3'd4;
        cmd_data_nxt  = ms_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state       <= IDLE;
      ret_q       <= IDLE;
      gap_cnt     <= 4'd0;
      hours_q     <= 5'd0;
      minutes_q   <= 6'd0;
      seconds_q   <= 6'd0;
      ms_q        <= 10'd0;
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= 3'd0;
      cmd_data_o  <= 10'd0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_nxt;
      ret_q       <= ret_nxt;
      gap_cnt     <= gap_cnt_nxt;
      cmd_valid_o <= cmd_valid_nxt;
      cmd_type_o  <= cmd_type_nxt;
      cmd_data_o  <= cmd_data_nxt;
      busy_o      <= busy_nxt;
      done_o      <= done_nxt;
      err_o       <= err_nxt;
      if (accept) begin
        hours_q   <= req_hours_i;
        minutes_q <= req_minutes_i;
        seconds_q <= req_seconds_i;
        ms_q      <= req_ms_i;
      end
    end
  end

endmodule
